// File: rtl/rsa_exp_io_pkg.sv
// Shared widths and FSM states for the word-serial front end
// of the 512-bit modular-exponentiation core.
package rsa_exp_io_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OP_W   = 512;
  localparam int unsigned NWORDS = OP_W / WORD_W;
  localparam int unsigned CNT_W  = $clog2(NWORDS);

  typedef enum logic [2:0] {
    LOAD_X,
    LOAD_E,
    LOAD_M,
    START,
    WAIT,
    UNLOAD
  } state_e;

endpackage

// File: rtl/rsa_word_deser.sv
// One OP_W operand register written a word at a time;
// word 0 lands in the least significant bits.
module rsa_word_deser
  import rsa_exp_io_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              we_i,
  input  logic [CNT_W-1:0]  idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [OP_W-1:0]   q_o
);

  logic [OP_W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_q <= '0;
    end else if (we_i) begin
      q_q[idx_i*WORD_W +: WORD_W] <= wdata_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/rsa_exp_io_ctrl.sv
// Host stream front end: 48 words in, start/done, 16 words out.
// Optional WAIT watchdog: define RSA_EXP_IO_TIMEOUT_EN.
module rsa_exp_io_ctrl
  import rsa_exp_io_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2**20
)
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              exp_start,
  output logic [OP_W-1:0]   exp_x,
  output logic [OP_W-1:0]   exp_e,
  output logic [OP_W-1:0]   exp_m,
  input  logic [OP_W-1:0]   exp_res,
  input  logic              exp_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_q;
  logic [OP_W-1:0]  res_q;
  logic             s_hs;
  logic             m_hs;
  logic             tmo;

  assign s_ready   = state_q inside {LOAD_X, LOAD_E, LOAD_M};
  assign m_valid   = state_q == UNLOAD;
  assign exp_start = state_q == START;
  assign m_data    = res_q[idx_q*WORD_W +: WORD_W];
  assign m_last    = m_valid && (idx_q == LAST);
  assign busy      = !(state_q == LOAD_X && cnt_q == '0);
  assign s_hs      = s_valid && s_ready;
  assign m_hs      = m_valid && m_ready;

  rsa_word_deser u_x (
    .clk     (clk),
    .resetn  (resetn),
    .we_i    (s_hs && state_q == LOAD_X),
    .idx_i   (cnt_q),
    .wdata_i (s_data),
    .q_o     (exp_x)
  );

  rsa_word_deser u_e (
    .clk     (clk),
    .resetn  (resetn),
    .we_i    (s_hs && state_q == LOAD_E),
    .idx_i   (cnt_q),
    .wdata_i (s_data),
    .q_o     (exp_e)
  );

  rsa_word_deser u_m (
    .clk     (clk),
    .resetn  (resetn),
    .we_i    (s_hs && state_q == LOAD_M),
    .idx_i   (cnt_q),
    .wdata_i (s_data),
    .q_o     (exp_m)
  );

`ifdef RSA_EXP_IO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tcnt_q;
  logic          terr_q;

  assign tmo         = tcnt_q == TW'(TIMEOUT_CYC - 1);
  assign timeout_err = terr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state_q == START) begin
        tcnt_q <= '0;
      end else if (state_q == WAIT) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      if (state_q == WAIT && !exp_done && tmo) begin
        terr_q <= 1'b1;
      end
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= LOAD_X;
      cnt_q   <= '0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        LOAD_X: if (s_hs) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= LOAD_E;
        end
        LOAD_E: if (s_hs) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= LOAD_M;
        end
        LOAD_M: if (s_hs) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= START;
        end
        START: state_q <= WAIT;
        WAIT: begin
          if (exp_done) begin
            res_q   <= exp_res;
            state_q <= UNLOAD;
          end else if (tmo) begin
            res_q   <= '0;
            state_q <= UNLOAD;
          end
        end
        UNLOAD: if (m_hs) begin
          idx_q <= idx_q + 1'b1;
          if (m_last) state_q <= LOAD_X;
        end
        default: state_q <= LOAD_X;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_exp_io_ctrl.sv
// Randomized bench for rsa_exp_io_ctrl; the bench itself
// plays the exponentiator and predicts every output word.
module tb_rsa_exp_io_ctrl;
  import rsa_exp_io_pkg::*;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_last;
  logic              exp_start;
  logic [OP_W-1:0]   exp_x;
  logic [OP_W-1:0]   exp_e;
  logic [OP_W-1:0]   exp_m;
  logic [OP_W-1:0]   exp_res;
  logic              exp_done;
  logic              busy;
  logic              timeout_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  logic [OP_W-1:0] prev_e;
  logic [OP_W-1:0] prev_m;

  always #5 clk = ~clk;

  rsa_exp_io_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .exp_start   (exp_start),
    .exp_x       (exp_x),
    .exp_e       (exp_e),
    .exp_m       (exp_m),
    .exp_res     (exp_res),
    .exp_done    (exp_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always @(posedge clk) begin
    if (resetn && exp_start) n_start++;
  end

  task automatic check(input string tag,
                       input logic [OP_W-1:0] got,
                       input logic [OP_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    logic [OP_W-1:0] v;
    for (int i = 0; i < NWORDS; i++) v[i*WORD_W +: WORD_W] = $urandom;
    return v;
  endfunction

  task automatic send_word(input logic [WORD_W-1:0] w);
    int g = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("s_ready_bound", 0, 1);
    @(negedge clk);
  endtask

  task automatic send_op(input logic [OP_W-1:0] op);
    for (int i = 0; i < NWORDS; i++) send_word(op[i*WORD_W +: WORD_W]);
  endtask

  task automatic load_job(input logic [OP_W-1:0] x,
                          input logic [OP_W-1:0] e,
                          input logic [OP_W-1:0] m,
                          input bit spur);
    int s0 = n_start;
    send_op(x);
    check("x_words", exp_x, x);
    check("e_hold", exp_e, prev_e);
    check("busy_load", busy, 1);
    if (spur) begin
      s_valid  = 1'b0;
      exp_res  = ~x;
      exp_done = 1'b1;
      @(negedge clk);
      exp_done = 1'b0;
      check("spur_m_valid", m_valid, 0);
      check("spur_s_ready", s_ready, 1);
      check("spur_start", exp_start, 0);
    end
    send_op(e);
    check("e_words", exp_e, e);
    check("m_hold", exp_m, prev_m);
    send_op(m);
    s_valid = 1'b0;
    check("start_pulse", exp_start, 1);
    check("start_s_ready", s_ready, 0);
    check("start_x", exp_x, x);
    check("start_e", exp_e, e);
    check("start_m", exp_m, m);
    prev_e = e;
    prev_m = m;
    @(negedge clk);
    check("start_once", exp_start, 0);
    check("n_start", n_start - s0, 1);
  endtask

  task automatic recv(input logic [OP_W-1:0] r, input int bp);
    int idx = 0;
    int cyc = 0;
    while (idx < NWORDS && cyc < 400) begin
      case (bp)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      check("m_valid", m_valid, 1);
      check("m_data", m_data, r[idx*WORD_W +: WORD_W]);
      check("m_last", m_last, idx == NWORDS - 1);
      if (m_ready) idx++;
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
    check("n_words", idx, NWORDS);
    check("unload_end", m_valid, 0);
    check("b2b_ready", s_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_job(input logic [OP_W-1:0] x,
                         input logic [OP_W-1:0] e,
                         input logic [OP_W-1:0] m,
                         input logic [OP_W-1:0] r,
                         input int bp,
                         input bit spur,
                         input bit rst_wait);
    int d;
    load_job(x, e, m, spur);
    d = $urandom_range(0, 20);
    repeat (d) @(negedge clk);
    check("wait_m_valid", m_valid, 0);
    check("wait_s_ready", s_ready, 0);
    check("wait_x", exp_x, x);
    if (rst_wait) begin
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check("rst_s_ready", s_ready, 1);
      check("rst_m_valid", m_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_x", exp_x, 0);
      check("rst_m", exp_m, 0);
      prev_e   = '0;
      prev_m   = '0;
      exp_res  = r;
      exp_done = 1'b1;
      @(negedge clk);
      exp_done = 1'b0;
      check("late_done", m_valid, 0);
      check("late_busy", busy, 0);
    end else begin
      exp_res  = r;
      exp_done = 1'b1;
      @(negedge clk);
      exp_done = 1'b0;
      exp_res  = ~r;
      check("done_m_valid", m_valid, 1);
      check("tmo_err", timeout_err, 0);
      recv(r, bp);
    end
  endtask

`ifdef RSA_EXP_IO_TIMEOUT_EN
  task automatic timeout_job();
    int n = 0;
    load_job(rand_op(), rand_op(), rand_op(), 1'b0);
    exp_res = rand_op();
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, 64);
    check("tmo_err_set", timeout_err, 1);
    recv('0, 1);
    check("tmo_sticky", timeout_err, 1);
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [OP_W-1:0] xo;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b0;
    exp_done = 1'b0;
    exp_res  = '0;
    prev_e   = '0;
    prev_m   = '0;
    repeat (3) @(negedge clk);
    check("reset_s_ready", s_ready, 1);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_last", m_last, 0);
    check("reset_start", exp_start, 0);
    check("reset_busy", busy, 0);
    check("reset_tmo", timeout_err, 0);
    check("reset_x", exp_x, 0);
    check("reset_e", exp_e, 0);
    check("reset_m", exp_m, 0);
    resetn = 1'b1;
    @(negedge clk);

    run_job(512'd5, 512'd3, 512'd13, 512'd8, 0, 1'b0, 1'b0);

    for (int i = 0; i < NWORDS; i++) xo[i*WORD_W +: WORD_W] = 32'h1000_0000 + i;
    run_job(xo, rand_op(), rand_op(), rand_op(), 1, 1'b1, 1'b0);

    run_job(rand_op(), rand_op(), rand_op(), rand_op(), 0, 1'b0, 1'b1);
    run_job(rand_op(), rand_op(), rand_op(), rand_op(), 1, 1'b0, 1'b0);

    for (int j = 0; j < 6; j++) begin
      run_job(rand_op(), rand_op(), rand_op(), rand_op(),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef RSA_EXP_IO_TIMEOUT_EN
    timeout_job();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
